// File: rtl/seven_segment_scan_driver_if.sv
// Bus between the datapath and the seven-segment scan driver: the value to
// show plus per-digit controls in, the board pin levels and frame marker out.
interface seven_segment_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_en;
  logic                lz_suppress;
  logic [6:0]          seg;
  logic                seg_dp;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  // Datapath side: supplies what to display, observes the pins.
  modport master (
    output value, dp, digit_en, lz_suppress,
    input  seg, seg_dp, an, frame_start
  );

  // Driver side: consumes the display request, drives the pins.
  modport slave (
    input  value, dp, digit_en, lz_suppress,
    output seg, seg_dp, an, frame_start
  );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. One digit is lit per
// PRESCALE-cycle slot, each slot opening with BLANK_CYCLES of all-dark output
// so the previous digit's segments never ghost onto the next anode. Inputs are
// captured once per frame so the displayed number never tears mid-scan.
module seven_segment_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1,
  parameter bit HEX_EN       = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seven_segment_scan_driver_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                snapshot;

  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_en;
  logic                shadow_lz;

  logic [DIGITS-1:0]   lead_zero;
  logic [3:0]          nibble;

  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;
  logic                seg_dp_d;

  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                seg_dp_q;
  logic                frame_start_q;

  // Nibble to active-low segment pattern, bits ordered g..a.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (!HEX_EN && n >= 4'hA) begin
      g = SEG_OFF;
    end
    return g;
  endfunction

  // The very first cycle of every frame is where the inputs get captured.
  assign snapshot = (idx == '0) && (cnt == '0);
  assign nibble   = shadow_value[{idx, 2'b00} +: 4];

  // Slot prescaler and digit index; idx steps once per PRESCALE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame snapshot of the display request, with a one-cycle frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value  <= '0;
      shadow_dp     <= '0;
      shadow_en     <= '0;
      shadow_lz     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= snapshot;
      if (snapshot) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp;
        shadow_en    <= bus.digit_en;
        shadow_lz    <= bus.lz_suppress;
      end
    end
  end

  // Mark each digit whose nibble and every more-significant nibble are zero.
  always_comb begin
    logic all_zero_above;
    lead_zero      = '0;
    all_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero_above = all_zero_above && (shadow_value[4*i +: 4] == 4'h0);
      lead_zero[i]   = all_zero_above;
    end
  end

  // Next pin levels: dark during the blanking window or for disabled digits.
  always_comb begin
    an_d     = '1;
    seg_d    = SEG_OFF;
    seg_dp_d = 1'b1;
    if (cnt >= CNT_BLANK && shadow_en[idx]) begin
      an_d[idx] = 1'b0;
      seg_dp_d  = ~shadow_dp[idx];
      if (shadow_lz && idx != '0 && lead_zero[idx]) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = glyph(nibble);
      end
    end
  end

  // Registered pin drivers so the board sees glitch-free levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      seg_dp_q <= 1'b1;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.seg_dp      = seg_dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: two instances share the same inputs,
// one with hex glyphs enabled and one without. A frame-level model pushes the
// expected pin levels for a whole frame each time a snapshot is due; a monitor
// pops them one cycle at a time once the DUT announces the frame.
module tb_seven_segment_scan_driver;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 1;
  localparam int FRAME    = DIGITS * PRESCALE;

  // Segment patterns g..a for nibbles 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg_hex;
    logic [6:0] seg_raw;
    logic       dp;
    logic       fs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [15:0] in_value = '0;
  logic [3:0]  in_dp    = '0;
  logic [3:0]  in_en    = '0;
  logic        in_lz    = 1'b0;

  int checks        = 0;
  int errors        = 0;
  int edge_cnt      = 0;
  int frames_pushed = 0;
  int frames_seen   = 0;
  int left          = 0;
  exp_t sbq[$];
  exp_t e;

  seven_segment_scan_driver_if #(.DIGITS(DIGITS)) bus_hex ();
  seven_segment_scan_driver_if #(.DIGITS(DIGITS)) bus_raw ();

  assign bus_hex.value       = in_value;
  assign bus_hex.dp          = in_dp;
  assign bus_hex.digit_en    = in_en;
  assign bus_hex.lz_suppress = in_lz;
  assign bus_raw.value       = in_value;
  assign bus_raw.dp          = in_dp;
  assign bus_raw.digit_en    = in_en;
  assign bus_raw.lz_suppress = in_lz;

  seven_segment_scan_driver #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK), .HEX_EN(1'b1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .bus(bus_hex)
  );

  seven_segment_scan_driver #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK), .HEX_EN(1'b0)
  ) dut_raw (
    .clk(clk), .rst_n(rst_n), .bus(bus_raw)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected pin levels for one whole frame, derived from the captured request.
  task automatic pushFrame(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] en, input logic lz);
    exp_t x;
    int slot;
    int pos;
    logic [3:0] nib;
    for (int j = 0; j < FRAME; j++) begin
      slot = j / PRESCALE;
      pos  = j % PRESCALE;
      x = '{an: 4'hF, seg_hex: 7'h7F, seg_raw: 7'h7F, dp: 1'b1, fs: (j == 0)};
      if (pos >= BLANK && en[slot]) begin
        nib  = 4'((v >> (4 * slot)) & 16'hF);
        x.an = 4'hF & ~(4'(1) << slot);
        x.dp = ~d[slot];
        if (!(lz && slot > 0 && (v >> (4 * slot)) == 16'h0)) begin
          x.seg_hex = GLYPH[nib];
          x.seg_raw = (nib >= 4'hA) ? 7'h7F : GLYPH[nib];
        end
      end
      sbq.push_back(x);
    end
    frames_pushed++;
  endtask

  // Reference timing: a snapshot falls on the first edge after reset and
  // then every FRAME edges.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      edge_cnt = 0;
    end else begin
      if (edge_cnt % FRAME == 0) begin
        pushFrame(in_value, in_dp, in_en, in_lz);
      end
      edge_cnt++;
    end
  end

  // Monitor: sample on the falling edge, pop one expected cycle per sample.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sbq.delete();
      left = 0;
      checkOutput("rst_an",     bus_hex.an,          4'hF);
      checkOutput("rst_seg",    bus_hex.seg,         7'h7F);
      checkOutput("rst_dp",     bus_hex.seg_dp,      1'b1);
      checkOutput("rst_fs",     bus_hex.frame_start, 1'b0);
      checkOutput("rst_raw_an", bus_raw.an,          4'hF);
    end else begin
      if (left == 0) begin
        if (sbq.size() != 0) begin
          checkOutput("frame_start_due", bus_hex.frame_start, 1'b1);
          if (bus_hex.frame_start) begin
            left = FRAME;
            frames_seen++;
          end else begin
            sbq.delete();
          end
        end else begin
          checkOutput("frame_start_idle", bus_hex.frame_start, 1'b0);
        end
      end
      if (left != 0) begin
        e = sbq.pop_front();
        left--;
        checkOutput("an",       bus_hex.an,          e.an);
        checkOutput("seg",      bus_hex.seg,         e.seg_hex);
        checkOutput("seg_dp",   bus_hex.seg_dp,      e.dp);
        checkOutput("fs",       bus_hex.frame_start, e.fs);
        checkOutput("raw_an",   bus_raw.an,          e.an);
        checkOutput("raw_seg",  bus_raw.seg,         e.seg_raw);
        checkOutput("raw_dp",   bus_raw.seg_dp,      e.dp);
        checkOutput("raw_fs",   bus_raw.frame_start, e.fs);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] en, input logic lz);
    in_value = v;
    in_dp    = d;
    in_en    = en;
    in_lz    = lz;
  endtask

  // Returns at the falling edge where frame_start is seen, bounded by a frame.
  task automatic waitFrameStart();
    bit found;
    found = 1'b0;
    for (int k = 0; k < FRAME + 4 && !found; k++) begin
      @(negedge clk);
      found = bus_hex.frame_start;
    end
    if (!found) begin
      checkOutput("wait_frame_start", bus_hex.frame_start, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] masks [4];
    masks[0] = 16'hFFFF;
    masks[1] = 16'h00FF;
    masks[2] = 16'h000F;
    masks[3] = 16'h0000;

    $display("[TB] reset");
    #1 rst_n = 1'b0;
    tick(3);
    applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
    #2 rst_n = 1'b1;
    tick(2 * FRAME);

    $display("[TB] hex glyphs");
    applyStimulus(16'hABCF, 4'h0, 4'hF, 1'b0);
    tick(2 * FRAME);

    $display("[TB] leading zeros");
    applyStimulus(16'h0050, 4'h0, 4'hF, 1'b1);
    tick(2 * FRAME);
    applyStimulus(16'h0000, 4'h0, 4'hF, 1'b1);
    tick(2 * FRAME);

    $display("[TB] snapshot timing");
    applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
    tick(FRAME + 5);
    applyStimulus(16'h5678, 4'h0, 4'hF, 1'b0);
    tick(FRAME);
    waitFrameStart();
    applyStimulus(16'h9ABC, 4'h0, 4'hF, 1'b0);
    tick(2 * FRAME);

    $display("[TB] enables and decimal points");
    applyStimulus(16'h1234, 4'b0001, 4'b0101, 1'b0);
    tick(2 * FRAME);

    $display("[TB] random");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(16'($urandom) & masks[$urandom_range(0, 3)],
                    4'($urandom), 4'($urandom), 1'($urandom));
      tick($urandom_range(1, 24));
    end

    $display("[TB] reset mid-scan");
    applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0);
    tick(2 * FRAME);
    waitFrameStart();
    tick(2 * PRESCALE + 2);
    checkOutput("pre_rst_an", bus_hex.an, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an",  bus_hex.an,          4'hF);
    checkOutput("async_rst_seg", bus_hex.seg,         7'h7F);
    checkOutput("async_rst_dp",  bus_hex.seg_dp,      1'b1);
    checkOutput("async_rst_fs",  bus_hex.frame_start, 1'b0);
    tick(3);
    #2 rst_n = 1'b1;
    tick(3 * FRAME);

    checkOutput("frames_seen", 16'(frames_seen), 16'(frames_pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
